// File: rtl/ddr4_sref_sequencer.sv
// Sequences AXI quiesce and MIG self-refresh entry from the shell's GPIO command byte,
// enforcing the req/ack handshakes with timeouts and reporting a status byte.
module ddr4_sref_sequencer #(
    parameter int QUIESCE_TIMEOUT = 4096,
    parameter int SREF_TIMEOUT    = 65536,
    parameter int CNT_W           = 17
) (
    input  logic       CLK_IN,
    input  logic       AXI_RESET_N,
    input  logic [7:0] SREF_CTRL_OUT,
    output logic [7:0] SREF_CTRL_IN,
    input  logic       init_calib_complete,
    output logic       quiesce_req,
    input  logic       quiesce_ack,
    output logic       app_sref_req,
    input  logic       app_sref_ack,
    output logic       app_restore_complete,
    output logic       app_mem_init_skip,
    output logic       app_xsdb_select
);

    typedef enum logic [2:0] {
        ST_WAIT_CALIB,
        ST_ACTIVE,
        ST_QUIESCE,
        ST_SREF_REQ,
        ST_IN_SREF,
        ST_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SREF_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             err;
    logic             bit0_prev;
    logic             sref_enter;
    logic             err_clear;
    logic             unused_ctrl_bits;

    assign sref_enter       = SREF_CTRL_OUT[0];
    assign err_clear        = SREF_CTRL_OUT[1];
    assign unused_ctrl_bits = ^SREF_CTRL_OUT[7:5];

    // Saturating increment so a stuck state can never wrap back into a live count
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge CLK_IN or negedge AXI_RESET_N) begin
        if (!AXI_RESET_N) begin
            state                <= ST_WAIT_CALIB;
            cnt                  <= '0;
            err                  <= 1'b0;
            bit0_prev            <= 1'b0;
            quiesce_req          <= 1'b0;
            app_sref_req         <= 1'b0;
            app_restore_complete <= 1'b0;
            app_mem_init_skip    <= 1'b0;
            app_xsdb_select      <= 1'b0;
            SREF_CTRL_IN         <= '0;
        end else begin
            bit0_prev <= sref_enter;
            {app_xsdb_select, app_mem_init_skip, app_restore_complete} <= SREF_CTRL_OUT[4:2];
            SREF_CTRL_IN <= {app_sref_ack, err, state == ST_IN_SREF, SREF_CTRL_OUT[4:0]};

            case (state)
                ST_WAIT_CALIB: begin
                    quiesce_req  <= 1'b0;
                    app_sref_req <= 1'b0;
                    if (init_calib_complete) begin
                        state <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (!init_calib_complete) begin
                        state <= ST_WAIT_CALIB;
                    end else if (sref_enter && !bit0_prev) begin
                        state       <= ST_QUIESCE;
                        cnt         <= '0;
                        quiesce_req <= 1'b1;
                    end
                end

                ST_QUIESCE: begin
                    if (!sref_enter) begin
                        state       <= ST_ACTIVE;
                        quiesce_req <= 1'b0;
                    end else if (quiesce_ack) begin
                        state        <= ST_SREF_REQ;
                        cnt          <= '0;
                        app_sref_req <= 1'b1;
                    end else if (cnt >= Q_LAST) begin
                        state       <= ST_ERROR;
                        quiesce_req <= 1'b0;
                        err         <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // The request cannot be withdrawn before ack, so bit0 is not looked at here
                ST_SREF_REQ: begin
                    if (app_sref_ack) begin
                        state <= ST_IN_SREF;
                    end else if (cnt >= S_LAST) begin
                        state        <= ST_ERROR;
                        quiesce_req  <= 1'b0;
                        app_sref_req <= 1'b0;
                        err          <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_IN_SREF: begin
                    quiesce_req  <= 1'b1;
                    app_sref_req <= 1'b1;
                end

                ST_ERROR: begin
                    quiesce_req  <= 1'b0;
                    app_sref_req <= 1'b0;
                    if (err_clear) begin
                        err   <= 1'b0;
                        state <= ST_WAIT_CALIB;
                    end
                end

                default: begin
                    state        <= ST_WAIT_CALIB;
                    quiesce_req  <= 1'b0;
                    app_sref_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr4_sref_sequencer.md
Name: ddr4_sref_sequencer

Overview:
- Hardware sequencer between the shell's 8-bit DDR self-refresh GPIO control register (CX_DDR_SREF_CTRL_OUT / CX_DDR_SREF_CTRL_IN) and one dynamic-region MIG's app_sref_* / app_restore_* pins.
- Replaces the raw bit pass-through: quiesces AXI traffic, requests self-refresh, enforces the MIG req/ack handshake with timeouts, and returns a status byte.
- One instance per dynamic-region DDR controller (C0, C2, C3), clocked in the MIG UI clock domain.

Parameters:
- QUIESCE_TIMEOUT, 4096, cycles allowed from quiesce_req to quiesce_ack.
- SREF_TIMEOUT, 65536, cycles allowed from app_sref_req to app_sref_ack.
- CNT_W, 17, timeout counter width; must hold max(QUIESCE_TIMEOUT, SREF_TIMEOUT).

Ports:
- CLK_IN  in  1  MIG UI clock; all logic is on this clock.
- AXI_RESET_N  in  1  reset, asynchronous assert, active-low.
- SREF_CTRL_OUT  in  8  GPIO command byte, synchronous to CLK_IN. [0] sref enter request (level), [1] error clear, [2] restore_complete, [3] mem_init_skip, [4] xsdb_select, [7:5] ignored.
- SREF_CTRL_IN  out  8  status byte to GPIO.
- init_calib_complete  in  1  MIG calibration done.
- quiesce_req  out  1  to AXI isolation: block new transactions and drain outstanding ones.
- quiesce_ack  in  1  AXI isolation reports idle.
- app_sref_req  out  1  to MIG.
- app_sref_ack  in  1  from MIG.
- app_restore_complete  out  1  to MIG.
- app_mem_init_skip  out  1  to MIG.
- app_xsdb_select  out  1  to MIG.

Behaviour:
- Reset values: all outputs 0; state WAIT_CALIB; counter 0; err 0.
- Config outputs: app_restore_complete, app_mem_init_skip and app_xsdb_select are SREF_CTRL_OUT[2], [3], [4], registered with 1-cycle latency, independent of state.
- WAIT_CALIB: bit0 is ignored. Go to ACTIVE on init_calib_complete=1.
- ACTIVE:
  - init_calib_complete=0 returns to WAIT_CALIB.
  - Bit0 rising edge (registered previous value; a level already 1 on calib entry does not trigger) goes to QUIESCE, clears the counter, and sets quiesce_req=1 in the same transition.
- QUIESCE: counter increments each cycle. Priority order:
  1. Bit0=0 (abort): drop quiesce_req, go to ACTIVE.
  2. quiesce_ack=1: go to SREF_REQ, clear counter, app_sref_req=1.
  3. Counter reaches QUIESCE_TIMEOUT-1: go to ERROR.
- SREF_REQ:
  - app_sref_req stays 1 until ack.
  - Bit0 falling does not abort here; the MIG protocol forbids withdrawing req before ack.
  - app_sref_ack=1 goes to IN_SREF.
  - Counter reaches SREF_TIMEOUT-1 goes to ERROR.
  - Ack and timeout in the same cycle: ack wins.
- IN_SREF:
  - app_sref_req and quiesce_req held at 1.
  - Exit only via AXI_RESET_N, since the MIG is re-initialised through reset/PR with mem_init_skip.
  - Bit0 changes are ignored.
- ERROR:
  - app_sref_req=0, quiesce_req=0, err=1 (sticky).
  - Bit1=1 clears err and goes to WAIT_CALIB. Bit1 is level-sensitive; software writes 1 then 0.
  - Bit1=1 outside ERROR has no effect.
- SREF_CTRL_IN, registered, 1-cycle latency:
  - [7] app_sref_ack
  - [6] err
  - [5] in_sref (state==IN_SREF)
  - [4:0] SREF_CTRL_OUT[4:0] echo, which preserves existing software readback.
- Timeout counter saturates; it never wraps.
- Mid-operation reset: all outputs go to 0 asynchronously. Reset release re-enters WAIT_CALIB.
- Encoding: state encoding is free. No combinational path from any input to any output.

Test Plan:
- Normal entry:
  - Stimulus: calib=1; bit0 0→1; quiesce_ack 5 cycles after quiesce_req; app_sref_ack 20 cycles after app_sref_req.
  - Required: quiesce_req rises 1 cycle after the edge; app_sref_req rises 1 cycle after quiesce_ack; SREF_CTRL_IN=0xA1 (ack, in_sref, bit0 echo) and held.
- Quiesce abort:
  - Stimulus: bit0 0→1, no quiesce_ack, bit0→0 after 10 cycles.
  - Required: quiesce_req drops next cycle; app_sref_req never asserts; err=0; a new bit0 edge restarts the sequence.
- Quiesce timeout:
  - Stimulus: QUIESCE_TIMEOUT=16, quiesce_ack never asserts.
  - Required: ERROR after 16 cycles, SREF_CTRL_IN[6]=1, quiesce_req=0. Bit1 pulse returns to WAIT_CALIB with [6]=0.
- Sref timeout vs. late ack:
  - Stimulus: SREF_TIMEOUT=32, ack on cycle 31.
  - Required: IN_SREF, no error. Repeat with ack on cycle 33: ERROR, app_sref_req=0.
- Calib gating:
  - Stimulus: bit0 already 1 while calib=0, then calib rises.
  - Required: no quiesce_req. Calib drop in ACTIVE returns to WAIT_CALIB.
- Reset and config:
  - Stimulus: assert AXI_RESET_N=0 in IN_SREF.
  - Required: all outputs 0 immediately.
  - Stimulus: bits[4:2]=3'b101.
  - Required: app_xsdb_select=1, app_mem_init_skip=0, app_restore_complete=1 one cycle later.
